// File: rtl/sync_fifo_almost.sv
// Single-clock FIFO with full/empty and programmable almost-full/almost-empty flags.
// Flags are registered from the next-state pointers, so they reflect the
// pointer state after each edge with no extra pipeline stage.
module sync_fifo_almost #(
    parameter int unsigned DATESIZE   = 8,
    parameter int unsigned ADDRSIZE   = 3,
    parameter int unsigned ALMOST_GAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATESIZE-1:0] wdata,
    input  logic                winc,
    input  logic                rinc,
    output logic [DATESIZE-1:0] rdata,
    output logic                wfull,
    output logic                rempty,
    output logic                almost_full,
    output logic                almost_empty
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam int unsigned PW    = ADDRSIZE + 1;

    logic [DATESIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic [PW-1:0] count_nxt;
    logic          wen;
    logic          ren;

    // Accept decisions and next-state pointers / occupancy.
    always_comb begin
        wen       = winc & ~wfull;
        ren       = rinc & ~rempty;
        wptr_nxt  = wptr + PW'(wen);
        rptr_nxt  = rptr + PW'(ren);
        count_nxt = wptr_nxt - rptr_nxt;
    end

    // Pointers and status flags; flags are derived from the post-edge occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            rempty       <= 1'b1;
            wfull        <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            rempty       <= (count_nxt == '0);
            wfull        <= (count_nxt == PW'(DEPTH));
            almost_full  <= (count_nxt >= PW'(DEPTH - ALMOST_GAP));
            almost_empty <= (count_nxt <= PW'(ALMOST_GAP));
        end
    end

    // Storage write; contents are not cleared by reset, but reset blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wen) begin
            mem[wptr[ADDRSIZE-1:0]] <= wdata;
        end
    end

    // Registered read data; holds until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[rptr[ADDRSIZE-1:0]];
        end
    end

endmodule

// File: tb/tb_sync_fifo_almost.sv
// Self-checking bench for sync_fifo_almost: queue-based reference model,
// per-cycle compare process, directed scenarios plus randomized traffic.
module tb_sync_fifo_almost;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned GAP   = 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] wdata;
    logic          winc;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          wfull;
    logic          rempty;
    logic          almost_full;
    logic          almost_empty;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rdata;
    bit            m_valid = 0;

    sync_fifo_almost #(
        .DATESIZE  (DW),
        .ADDRSIZE  (AW),
        .ALMOST_GAP(GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wdata       (wdata),
        .winc        (winc),
        .rinc        (rinc),
        .rdata       (rdata),
        .wfull       (wfull),
        .rempty      (rempty),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_rdata = '0;
            m_valid = 1;
        end else if (m_valid) begin
            automatic bit was_full  = (m_q.size() == DEPTH);
            automatic bit was_empty = (m_q.size() == 0);
            if (rinc && !was_empty) m_rdata = m_q.pop_front();
            if (winc && !was_full)  m_q.push_back(wdata);
        end
    end

    // Compare DUT against model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            automatic int n = m_q.size();
            check("rdata",        32'(rdata),        32'(m_rdata));
            check("rempty",       32'(rempty),       32'(n == 0));
            check("wfull",        32'(wfull),        32'(n == DEPTH));
            check("almost_full",  32'(almost_full),  32'(n >= int'(DEPTH - GAP)));
            check("almost_empty", 32'(almost_empty), 32'(n <= int'(GAP)));
        end
    end

    // Drive one cycle: inputs change on the falling edge; returns just after the rising edge.
    task automatic tick(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        @(negedge clk);
        winc  = w;
        rinc  = r;
        wdata = d;
        rst   = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;

        // Reset with concurrent requests
        tick(1, 1, 8'hAA, 1);
        tick(1, 1, 8'hAB, 1);
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_wfull",  32'(wfull),  32'd0);
        check("rst_ae",     32'(almost_empty), 32'd1);
        check("rst_af",     32'(almost_full),  32'd0);
        check("rst_rdata",  32'(rdata),  32'd0);
        tick(0, 0, 0, 0);
        check("rst_nowrite", 32'(rempty), 32'd1);

        // Fill 1..8
        for (int i = 1; i <= 8; i++) begin
            tick(1, 0, 8'(i), 0);
            check("fill_ae",    32'(almost_empty), 32'(i < 2));
            check("fill_af",    32'(almost_full),  32'(i >= 7));
            check("fill_wfull", 32'(wfull),        32'(i == 8));
        end
        tick(1, 0, 8'd9, 0);
        check("overflow_wfull", 32'(wfull), 32'd1);

        // Drain 8, then one underflow read
        for (int i = 1; i <= 8; i++) begin
            tick(0, 1, 0, 0);
            check("drain_rdata",  32'(rdata),  32'(i));
            check("drain_rempty", 32'(rempty), 32'(i == 8));
        end
        tick(0, 1, 0, 0);
        check("underflow_rdata", 32'(rdata), 32'd8);

        // Simultaneous read/write at count 4, pointers wrap
        for (int i = 0; i < 4; i++) tick(1, 0, 8'(10 + i), 0);
        for (int k = 0; k < 10; k++) begin
            tick(1, 1, 8'(20 + k), 0);
            check("simul_rdata", 32'(rdata), (k < 4) ? 32'(10 + k) : 32'(20 + k - 4));
            check("simul_ae",    32'(almost_empty), 32'd0);
            check("simul_af",    32'(almost_full),  32'd0);
        end

        // Boundary: full with both requests
        for (int i = 0; i < 4; i++) tick(1, 0, 8'(30 + i), 0);
        check("bnd_full", 32'(wfull), 32'd1);
        tick(1, 1, 8'd99, 0);
        check("bnd_full_rdata", 32'(rdata), 32'd26);
        check("bnd_full_wfull", 32'(wfull), 32'd0);
        check("bnd_full_af",    32'(almost_full), 32'd1);
        for (int i = 0; i < 7; i++) tick(0, 1, 0, 0);
        check("bnd_drained_rdata", 32'(rdata), 32'd33);
        check("bnd_empty", 32'(rempty), 32'd1);
        // Boundary: empty with both requests
        tick(1, 1, 8'd55, 0);
        check("bnd_empty_rdata",  32'(rdata),  32'd33);
        check("bnd_empty_rempty", 32'(rempty), 32'd0);
        check("bnd_empty_ae",     32'(almost_empty), 32'd1);
        tick(0, 1, 0, 0);
        check("bnd_empty_read", 32'(rdata), 32'd55);

        // Mid-operation reset at count 5
        for (int i = 0; i < 5; i++) tick(1, 0, 8'(60 + i), 0);
        tick(1, 1, 8'd70, 1);
        check("midrst_rempty", 32'(rempty), 32'd1);
        check("midrst_rdata",  32'(rdata),  32'd0);
        tick(1, 0, 8'd77, 0);
        tick(0, 1, 0, 0);
        check("midrst_newdata", 32'(rdata), 32'd77);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            automatic int unsigned phase = (c / 300) % 3;
            automatic logic w = ($urandom_range(99) < (phase == 0 ? 75 : (phase == 1 ? 25 : 50)));
            automatic logic r = ($urandom_range(99) < (phase == 0 ? 25 : (phase == 1 ? 75 : 50)));
            automatic logic rs = ($urandom_range(299) == 0);
            tick(w, r, 8'($urandom), rs);
        end

        tick(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
